// File: rtl/mips_pkg.sv
// Shared MIPS core types: multiply/divide opcodes and MDU sequencer states.
package mips_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Final sign correction of the unsigned iteration result; pure combinational.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw_i,
  input  logic               is_div_i,
  input  logic               neg_a_i,
  input  logic               neg_b_i,
  input  logic               div0_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic               flip;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign flip = neg_a_i ^ neg_b_i;

  always_comb begin
    prod = flip ? -raw_i : raw_i;
    quo  = raw_i[WIDTH-1:0];
    rem  = raw_i[2*WIDTH-1:WIDTH];
    hi_o = prod[2*WIDTH-1:WIDTH];
    lo_o = prod[WIDTH-1:0];
    if (is_div_i) begin
      // Divide by zero leaves |a| as remainder, so the dividend-sign fix restores a exactly.
      lo_o = div0_i ? {WIDTH{1'b1}} : (flip ? -quo : quo);
      hi_o = neg_a_i ? -rem : rem;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    src_a_i,
  input  logic [WIDTH-1:0]    src_b_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign sgn   = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign a_neg = sgn & src_a_i[WIDTH-1];
  assign b_neg = sgn & src_b_i[WIDTH-1];
  assign a_mag = a_neg ? -src_a_i : src_a_i;
  assign b_mag = b_neg ? -src_b_i : src_b_i;

  // Multiply: upper half accumulates, multiplier bits retire out of the bottom.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide: remainder in the upper half, quotient bits enter at the bottom.
  assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, opnd_q};
  assign div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw_i    (acc_q),
    .is_div_i (is_div_q),
    .neg_a_i  (neg_a_q),
    .neg_b_i  (neg_b_q),
    .div0_i   (div0_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          case (op_i)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d  = RUN;
              cnt_d    = '0;
              is_div_d = op_i[1];
              neg_a_d  = a_neg;
              neg_b_d  = b_neg;
              div0_d   = op_i[1] && (src_b_i == '0);
              acc_d    = {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
              opnd_d   = op_i[1] ? b_mag : a_mag;
            end
            MDU_MTHI: hi_d = src_a_i;
            MDU_MTLO: lo_d = src_a_i;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
          else                          cnt_d   = cnt_q + 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush_i) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, random ops vs arithmetic model, corner sequences.
module tb_mult_div_unit;

  logic        clk, rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .start_i (start),
    .op_i    (op),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rhi, output logic [31:0] rlo);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rhi = 32'h0;
    rlo = 32'h0;
    case (o)
      3'd0: begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; rhi = p[63:32]; rlo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'h0) begin
          rlo = 32'hFFFF_FFFF;
          rhi = a;
        end else if (o == 3'd2) begin
          p = sa / sb; rlo = p[31:0];
          p = sa % sb; rhi = p[31:0];
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic run_arith(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] ehi, elo;
    model(o, a, b, ehi, elo);
    launch(o, a, b);
    chk({tag, " busy after start"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'd33);
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " busy in done cycle"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    logic saw_done;
    logic [31:0] ehi, elo;

    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h3,         32'h2,         32'hFFFF_FFFD};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{3'd3, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[6] = '{3'd2, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd6; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
      wait_done(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd33);
      chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      @(posedge clk); #1;
      chk($sformatf("vec%0d done one cycle", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 30; i++)
      run_arith($sformatf("rnd%0d", i), 3'($urandom_range(0, 3)), pick(), pick());

    // MTLO / MTHI while idle, then a no-op opcode
    launch(3'd5, 32'h55, 32'h0);
    chk("mtlo lo", lo, 32'h55);
    chk("mtlo done", 32'(done), 32'd0);
    chk("mtlo busy", 32'(busy), 32'd0);
    launch(3'd4, 32'h1111, 32'h0);
    chk("mthi hi", hi, 32'h1111);
    launch(3'd6, 32'hDEAD, 32'hBEEF);
    chk("nop busy", 32'(busy), 32'd0);
    chk("nop hi", hi, 32'h1111);
    chk("nop lo", lo, 32'h55);

    // MTHI while busy is dropped
    launch(3'd0, 32'd5, 32'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd4; src_a = 32'hAAAA;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi busy hi untouched", hi, 32'h1111);
    wait_done(lat);
    chk("mthi busy latency", 32'(lat), 32'd29);
    chk("mthi busy hi", hi, 32'h0);
    chk("mthi busy lo", lo, 32'd30);

    // back-to-back start in the done cycle
    start = 1'b1; op = 3'd1; src_a = 32'd7; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b busy", 32'(busy), 32'd1);
    chk("b2b done low", 32'(done), 32'd0);
    wait_done(lat);
    chk("b2b latency", 32'(lat), 32'd33);
    chk("b2b lo", lo, 32'd63);
    chk("b2b hi", hi, 32'd0);

    // flush mid-run
    launch(3'd0, 32'd5, 32'd6);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("flush no done", 32'(saw_done), 32'd0);
    chk("flush hi kept", hi, 32'd0);
    chk("flush lo kept", lo, 32'd63);

    // flush with start in the same cycle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd2; src_a = 32'd50; src_b = 32'd5;
    @(posedge clk); #1;
    chk("flush+start no launch", 32'(busy), 32'd0);
    @(negedge clk);
    op = 3'd5; src_a = 32'h77;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush+mtlo no write", lo, 32'd63);

    // reset mid-run
    launch(3'd0, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset hi", hi, 32'h0);
    chk("mid reset lo", lo, 32'h0);
    chk("mid reset done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("post reset quiet", 32'(saw_done), 32'd0);

    // one more op after reset recovers normally
    model(3'd2, 32'hFFFF_FF9C, 32'd7, ehi, elo);
    run_arith("post reset div", 3'd2, 32'hFFFF_FF9C, 32'd7);
    chk("model sanity lo", elo, 32'hFFFF_FFF2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the pipelined MIPS core, sitting in the EX stage directly downstream of the register file read ports. It consumes the two source operands read from the register file, executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles, and holds the architectural HI/LO registers. MFHI/MFLO read HI/LO directly, and the result flows to the register file's write-back path. The hazard unit stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; iteration count.
- `clk`  in  1  clock; rising edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6–7 are no-ops.
- `src_a`  in  WIDTH  rs operand (RD1 path); dividend / multiplicand / MTHI/MTLO data.
- `src_b`  in  WIDTH  rt operand (RD2 path); divisor / multiplier.
- `flush`  in  1  abort the in-flight operation (branch/exception squash).
- `busy`  out  1  operation in progress; reset 0.
- `done`  out  1  one-cycle pulse when HI/LO are updated by an arithmetic op; reset 0.
- `hi`  out  WIDTH  HI register; reset 0.
- `lo`  out  WIDTH  LO register; reset 0.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE:**
  - `start` with op 0–3: latch operand magnitudes, the sign flags (ops 0 and 2 only) and op; clear the iteration counter; go to RUN.
  - `start` with op 4/5: write `src_a` into HI/LO in the same edge and stay in IDLE; `done` is not asserted.
  - `start` with op 6–7: ignored.
- **RUN:** one radix-2 step per cycle over a single 2×WIDTH shift register.
  - Multiply uses shift-add.
  - Divide uses restoring division.
  - After WIDTH steps (counter == WIDTH-1 at the edge), go to FIX.
- **FIX:**
  - Apply sign correction:
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Write HI/LO; pulse `done`; go to IDLE.
- **Results:**
  - Multiply: HI/LO = upper/lower half of the 2×WIDTH product.
  - Divide: LO = quotient, HI = remainder.
- **Divide by zero** (signed or unsigned): LO = all ones, HI = `src_a` as given (unmodified); latency unchanged.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- **Arithmetic:** two's-complement, WIDTH-bit wrap. Magnitude of the most negative value is handled as unsigned WIDTH bits.
- **`start` while busy:** ignored. The hazard unit must hold the instruction, and MTHI/MTLO are likewise ignored while busy.
- **`flush`:**
  - In RUN or FIX: return to IDLE on the next edge; HI/LO unchanged; no `done`.
  - In IDLE: suppresses `start`. `flush` and `start` in the same cycle means flush wins.
- **Reset** (any time, including mid-operation): state IDLE, HI/LO/busy/done = 0, counter = 0.

## Timing
- Start edge E0 (IDLE, `start`=1, op 0–3):
  - `busy` = 1 after E0.
  - RUN occupies edges E1..E32 (WIDTH=32).
  - FIX edge E33 updates HI/LO.
  - After E33: `busy` = 0 and `done` = 1 for exactly one cycle.
- Latency is WIDTH+1 edges from the start edge to valid HI/LO, fixed and independent of operand values.
- `busy` is registered (a state ≠ IDLE decode of registered state); no combinational path from `start` to `busy`.
- A back-to-back `start` is accepted on the edge where `done` is high (state is already IDLE).
- MTHI/MTLO take effect at the accepting edge; visible on `hi`/`lo` the next cycle.
- HI/LO update only at FIX or MTHI/MTLO edges; they are stable otherwise.

## Structure
- Shared package `mips_pkg`:
  - `mdu_op_t` enum (values above).
  - `mdu_state_t` enum {IDLE, RUN, FIX}.
  - Constant `MDU_OP_W = 3`.
- One sub-module is natural: `mdu_sign_fix`, a combinational negate/select for the FIX stage that takes the raw HI/LO and sign flags. The iteration datapath stays in `mult_div_unit`.
- The hazard unit consumes `busy`. The forwarding mux consumes `hi`/`lo` for MFHI/MFLO.

## Test plan
- **Reset:** assert `reset`=0 mid-RUN after a MULT launch → next cycle `hi`=`lo`=0, `busy`=0, `done`=0; no later `done`.
- **MULT:** MULT 0xFFFFFFFF × 0x00000003 (−1×3) → after 33 edges `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFD. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFD.
- **DIV:** DIV 0xFFFFFFF9 / 0x00000002 (−7/2) → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100/7 → `lo`=14, `hi`=2.
- **Corner divides:** DIVU 0x1234 / 0 → `lo`=0xFFFFFFFF, `hi`=0x1234. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **flush:** start MULT 5×6, assert `flush` at E10 → `busy` = 0 after E11, HI/LO keep prior values, no `done`. `flush`+`start` in the same cycle → no launch.
- **Busy/back-to-back:**
  - MTHI 0xAAAA while busy → ignored.
  - MTLO 0x55 while IDLE → `lo`=0x55 next cycle, no `done`.
  - New `start` in the `done` cycle → accepted, `busy` stays 1.
